// File: rtl/pool_pkg.sv
// Shared definitions for the pooling window generator and avg_pool_2d:
// window size helper, flat packing index and the window FSM state type.
package pool_pkg;

    typedef enum logic [1:0] {
        FILL,
        EMIT,
        SKIP
    } pool_win_state_e;

    function automatic int win_elems(input int ker_x, input int ker_y, input int nfmaps);
        return ker_x * ker_y * nfmaps;
    endfunction

    // ky = 0 is the oldest row, kx = 0 the leftmost column
    function automatic int win_idx(input int ky, input int kx, input int f,
                                   input int ker_x = 2, input int nfmaps = 4);
        return (ky * ker_x + kx) * nfmaps + f;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Line buffer holding the KER_SIZE_Y-1 older rows of the current band, with one
// write port and a combinational KER_SIZE_X-wide column read across all rows.
module pool_line_buf
    import pool_pkg::*;
#(
    parameter int NBITS      = 8,
    parameter int NFMAPS     = 4,
    parameter int KER_SIZE_X = 2,
    parameter int KER_SIZE_Y = 2,
    parameter int IMG_WIDTH  = 8,
    localparam int PW    = NBITS * NFMAPS,
    localparam int CW    = $clog2(IMG_WIDTH),
    localparam int BW    = $clog2(KER_SIZE_Y),
    localparam int DEPTH = (KER_SIZE_Y - 1) * IMG_WIDTH,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
)(
    input  logic                                   clk,
    input  logic                                   wr_en,
    input  logic [BW-1:0]                          wr_row,
    input  logic [CW-1:0]                          wr_col,
    input  logic [PW-1:0]                          wr_data,
    input  logic [CW-1:0]                          rd_col,
    output logic [(KER_SIZE_Y-1)*KER_SIZE_X*PW-1:0] rd_data
);

    logic [PW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_addr;

    always_comb begin
        wr_addr = AW'(int'(wr_row) * IMG_WIDTH + int'(wr_col));
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Columns past the row end only occur for tail positions that never complete
    always_comb begin
        int c;
        int a;
        c = 0;
        a = 0;
        rd_data = '0;
        for (int r = 0; r < KER_SIZE_Y - 1; r++) begin
            for (int k = 0; k < KER_SIZE_X; k++) begin
                c = int'(rd_col) + k;
                a = r * IMG_WIDTH + c;
                if (c < IMG_WIDTH) begin
                    rd_data[PW*(r*KER_SIZE_X+k) +: PW] = mem_q[AW'(a)];
                end
            end
        end
    end

endmodule

// File: rtl/pool_window_gen.sv
// Raster-order pixel stream to non-overlapping pooling windows, packed for avg_pool_2d.
// Optional macro POOL_WIN_SOF_EN adds in_sof to restart framing at any pixel.
module pool_window_gen
    import pool_pkg::*;
#(
    parameter int NBITS      = 8,
    parameter int NFMAPS     = 4,
    parameter int KER_SIZE_X = 2,
    parameter int KER_SIZE_Y = 2,
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8
)(
    input  logic                                             clk,
    input  logic                                             rstn,
    input  logic                                             in_valid,
    input  logic [NBITS*NFMAPS-1:0]                          in_act,
`ifdef POOL_WIN_SOF_EN
    input  logic                                             in_sof,
`endif
    output logic                                             out_valid,
    output logic [NBITS*NFMAPS*KER_SIZE_X*KER_SIZE_Y-1:0]    out_act,
    output logic                                             out_frame_done
);

    localparam int PW        = NBITS * NFMAPS;
    localparam int WIN_ELEMS = win_elems(KER_SIZE_X, KER_SIZE_Y, NFMAPS);
    localparam int OW        = NBITS * WIN_ELEMS;
    localparam int CW        = $clog2(IMG_WIDTH);
    localparam int RW        = $clog2(IMG_HEIGHT);
    localparam int BW        = $clog2(KER_SIZE_Y);
    localparam int TAIL_COL  = (IMG_WIDTH / KER_SIZE_X) * KER_SIZE_X;
    localparam int TAIL_ROW  = (IMG_HEIGHT / KER_SIZE_Y) * KER_SIZE_Y;

    logic [CW-1:0]          col_q, col_d;
    logic [RW-1:0]          row_q, row_d;
    pool_win_state_e        state_q, state_d, estate;
    logic                   out_valid_q, out_valid_d;
    logic [OW-1:0]          out_act_q, out_act_d;
    logic                   frame_done_q, frame_done_d;
    logic [KER_SIZE_X*PW-1:0] stage_q, stage_d;
    logic [OW-1:0]          win;
    logic                   sof;
    logic                   lb_wr_en;
    logic [(KER_SIZE_Y-1)*KER_SIZE_X*PW-1:0] lb_rd;
    int                     ecol, erow, kx, band, base;

    function automatic pool_win_state_e row_state(input int r);
        if (r >= TAIL_ROW) begin
            return SKIP;
        end else if (r % KER_SIZE_Y == KER_SIZE_Y - 1) begin
            return EMIT;
        end
        return FILL;
    endfunction

`ifdef POOL_WIN_SOF_EN
    assign sof = in_valid & in_sof;
`else
    assign sof = 1'b0;
`endif

    // A start-of-frame pixel is treated as position (0,0) in FILL
    always_comb begin
        ecol   = sof ? 0 : int'(col_q);
        erow   = sof ? 0 : int'(row_q);
        estate = sof ? FILL : state_q;
        kx     = ecol % KER_SIZE_X;
        band   = erow % KER_SIZE_Y;
        base   = ecol - kx;
    end

    pool_line_buf #(
        .NBITS      (NBITS),
        .NFMAPS     (NFMAPS),
        .KER_SIZE_X (KER_SIZE_X),
        .KER_SIZE_Y (KER_SIZE_Y),
        .IMG_WIDTH  (IMG_WIDTH)
    ) u_line_buf (
        .clk     (clk),
        .wr_en   (lb_wr_en),
        .wr_row  (BW'(band)),
        .wr_col  (CW'(ecol)),
        .wr_data (in_act),
        .rd_col  (CW'(base)),
        .rd_data (lb_rd)
    );

    // Buffered rows fill ky < KER_SIZE_Y-1; the last row comes from staging plus the live pixel
    always_comb begin
        win = '0;
        for (int ky = 0; ky < KER_SIZE_Y; ky++) begin
            for (int x = 0; x < KER_SIZE_X; x++) begin
                for (int f = 0; f < NFMAPS; f++) begin
                    if (ky < KER_SIZE_Y - 1) begin
                        win[NBITS*win_idx(ky, x, f, KER_SIZE_X, NFMAPS) +: NBITS] =
                            lb_rd[PW*(ky*KER_SIZE_X+x) + NBITS*f +: NBITS];
                    end else if (x == KER_SIZE_X - 1) begin
                        win[NBITS*win_idx(ky, x, f, KER_SIZE_X, NFMAPS) +: NBITS] =
                            in_act[NBITS*f +: NBITS];
                    end else begin
                        win[NBITS*win_idx(ky, x, f, KER_SIZE_X, NFMAPS) +: NBITS] =
                            stage_q[PW*x + NBITS*f +: NBITS];
                    end
                end
            end
        end
    end

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        state_d      = state_q;
        out_valid_d  = 1'b0;
        out_act_d    = out_act_q;
        frame_done_d = 1'b0;
        stage_d      = stage_q;
        lb_wr_en     = 1'b0;
        if (in_valid) begin
            lb_wr_en = (estate == FILL);
            if (estate == EMIT) begin
                stage_d[PW*kx +: PW] = in_act;
                if (kx == KER_SIZE_X - 1 && ecol < TAIL_COL) begin
                    out_valid_d = 1'b1;
                    out_act_d   = win;
                end
            end
            if (ecol == IMG_WIDTH - 1) begin
                col_d = '0;
                if (erow == IMG_HEIGHT - 1) begin
                    row_d        = '0;
                    state_d      = FILL;
                    frame_done_d = 1'b1;
                end else begin
                    row_d   = RW'(erow + 1);
                    state_d = row_state(erow + 1);
                end
            end else begin
                col_d   = CW'(ecol + 1);
                row_d   = RW'(erow);
                state_d = estate;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col_q        <= '0;
            row_q        <= '0;
            state_q      <= FILL;
            out_valid_q  <= 1'b0;
            out_act_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            out_act_q    <= out_act_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_ff @(posedge clk) begin
        stage_q <= stage_d;
    end

    assign out_valid      = out_valid_q;
    assign out_act        = out_act_q;
    assign out_frame_done = frame_done_q;

endmodule

// File: tb/tb_pool_window_gen.sv
// Scoreboard bench for pool_window_gen with 4x4 and 5x5 image instances.
module tb_pool_window_gen;

    logic         clk = 1'b0;
    logic         rstn;
    logic         in_valid4, in_valid5;
    logic [31:0]  in_act;
`ifdef POOL_WIN_SOF_EN
    logic         in_sof;
`endif
    logic         ov4, ov5, fd4, fd5;
    logic [127:0] oa4, oa5;

    always #5 clk = ~clk;

    pool_window_gen #(.NBITS(8), .NFMAPS(4), .KER_SIZE_X(2), .KER_SIZE_Y(2),
                      .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut4 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid4), .in_act(in_act),
`ifdef POOL_WIN_SOF_EN
        .in_sof(in_sof),
`endif
        .out_valid(ov4), .out_act(oa4), .out_frame_done(fd4));

    pool_window_gen #(.NBITS(8), .NFMAPS(4), .KER_SIZE_X(2), .KER_SIZE_Y(2),
                      .IMG_WIDTH(5), .IMG_HEIGHT(5)) dut5 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid5), .in_act(in_act),
`ifdef POOL_WIN_SOF_EN
        .in_sof(in_sof),
`endif
        .out_valid(ov5), .out_act(oa5), .out_frame_done(fd5));

    typedef struct {
        logic [127:0] act;
        int           cyc;
    } exp_t;

    typedef struct {
        int sel;
        int w;
        int h;
        int frames;
        bit gaps;
        int exp_win;
        int exp_fd;
    } case_t;

    exp_t         q4[$], q5[$];
    int           fq4[$], fq5[$];
    int           n_tests = 0;
    int           n_fail = 0;
    int           cyc = 0;
    int           sel = 0;
    int           win_cnt[2];
    int           fd_cnt[2];
    logic [127:0] first_win;
    logic [127:0] last_exp;
    bit           first_seen;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pv(input int r, input int c, input int f);
        return 8'(16 * f + 4 * r + c);
    endfunction

    task automatic mon_one(input int d, input logic v, input logic [127:0] act, input logic fd);
        exp_t e;
        int   fc;
        if (v) begin
            if ((d == 0 && q4.size() == 0) || (d == 1 && q5.size() == 0)) begin
                n_tests++;
                n_fail++;
                $display("FAIL stray_window dut%0d: out_valid=1 at cycle %0d, none expected", d, cyc);
            end else begin
                e = (d == 0) ? q4.pop_front() : q5.pop_front();
                chk("window_data", act, e.act);
                chk_int("window_cycle", cyc, e.cyc);
            end
            win_cnt[d]++;
            if (d == 0 && !first_seen) begin
                first_win  = act;
                first_seen = 1'b1;
            end
        end
        if (fd) begin
            if ((d == 0 && fq4.size() == 0) || (d == 1 && fq5.size() == 0)) begin
                n_tests++;
                n_fail++;
                $display("FAIL stray_frame_done dut%0d: pulse at cycle %0d, none expected", d, cyc);
            end else begin
                fc = (d == 0) ? fq4.pop_front() : fq5.pop_front();
                chk_int("frame_done_cycle", cyc, fc);
            end
            fd_cnt[d]++;
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        mon_one(0, ov4, oa4, fd4);
        mon_one(1, ov5, oa5, fd5);
    endtask

    task automatic pix(input int r, input int c, input bit sof, input int w, input int h);
        exp_t e;
        for (int f = 0; f < 4; f++) in_act[8*f +: 8] = pv(r, c, f);
        in_valid4 = (sel == 0);
        in_valid5 = (sel == 1);
`ifdef POOL_WIN_SOF_EN
        in_sof = sof;
`endif
        if (r % 2 == 1 && c % 2 == 1 && r < (h / 2) * 2 && c < (w / 2) * 2) begin
            e.act = '0;
            for (int ky = 0; ky < 2; ky++)
                for (int x = 0; x < 2; x++)
                    for (int f = 0; f < 4; f++)
                        e.act[8*((ky*2+x)*4+f) +: 8] = pv(r - 1 + ky, c - 1 + x, f);
            e.cyc    = cyc + 1;
            last_exp = e.act;
            if (sel == 0) q4.push_back(e); else q5.push_back(e);
        end
        if (r == h - 1 && c == w - 1 && !sof) begin
            if (sel == 0) fq4.push_back(cyc + 1); else fq5.push_back(cyc + 1);
        end
        step();
        in_valid4 = 1'b0;
        in_valid5 = 1'b0;
`ifdef POOL_WIN_SOF_EN
        in_sof = 1'b0;
`endif
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic frame(input int w, input int h, input bit gaps);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) begin
                if (gaps && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
                pix(r, c, 1'b0, w, h);
            end
    endtask

    task automatic do_reset();
        in_valid4 = 1'b0;
        in_valid5 = 1'b0;
        rstn = 1'b0;
        q4.delete(); q5.delete(); fq4.delete(); fq5.delete();
        step();
        chk("rst_out_valid4", {127'b0, ov4}, '0);
        chk("rst_out_act4", oa4, '0);
        chk("rst_frame_done4", {127'b0, fd4}, '0);
        chk("rst_out_valid5", {127'b0, ov5}, '0);
        chk("rst_out_act5", oa5, '0);
        chk("rst_frame_done5", {127'b0, fd5}, '0);
        rstn = 1'b1;
        step();
        win_cnt[0] = 0; win_cnt[1] = 0;
        fd_cnt[0]  = 0; fd_cnt[1]  = 0;
    endtask

    task automatic drain_check(input int d, input int exp_win, input int exp_fd);
        idle(4);
        chk_int("window_count", win_cnt[d], exp_win);
        chk_int("frame_done_count", fd_cnt[d], exp_fd);
        chk_int("pending_windows", (d == 0) ? q4.size() : q5.size(), 0);
        chk_int("pending_frame_done", (d == 0) ? fq4.size() : fq5.size(), 0);
        chk("out_act_hold", (d == 0) ? oa4 : oa5, last_exp);
    endtask

    initial begin
        case_t cases[4];
        int    eidx[8];
        int    ebyte[8];
        cases[0] = '{sel: 0, w: 4, h: 4, frames: 1, gaps: 1'b0, exp_win: 4, exp_fd: 1};
        cases[1] = '{sel: 0, w: 4, h: 4, frames: 1, gaps: 1'b1, exp_win: 4, exp_fd: 1};
        cases[2] = '{sel: 1, w: 5, h: 5, frames: 1, gaps: 1'b0, exp_win: 4, exp_fd: 1};
        cases[3] = '{sel: 0, w: 4, h: 4, frames: 2, gaps: 1'b0, exp_win: 8, exp_fd: 2};
        eidx  = '{0, 4, 8, 12, 3, 7, 11, 15};
        ebyte = '{0, 1, 4, 5, 48, 49, 52, 53};

        in_act     = '0;
        in_valid4  = 1'b0;
        in_valid5  = 1'b0;
`ifdef POOL_WIN_SOF_EN
        in_sof     = 1'b0;
`endif
        rstn       = 1'b1;
        first_seen = 1'b0;
        last_exp   = '0;

        for (int i = 0; i < 4; i++) begin
            do_reset();
            sel = cases[i].sel;
            for (int fr = 0; fr < cases[i].frames; fr++) frame(cases[i].w, cases[i].h, cases[i].gaps);
            drain_check(cases[i].sel, cases[i].exp_win, cases[i].exp_fd);
            if (i == 0) begin
                for (int k = 0; k < 8; k++) chk_int("first_window_byte", int'(first_win[8*eidx[k] +: 8]), ebyte[k]);
            end
        end

        // Reset after five pixels of a frame, then a clean frame
        do_reset();
        sel = 0;
        for (int k = 0; k < 5; k++) pix(k / 4, k % 4, 1'b0, 4, 4);
        do_reset();
        frame(4, 4, 1'b0);
        drain_check(0, 4, 1);

`ifdef POOL_WIN_SOF_EN
        // Abandon frame 1 after six pixels with in_sof on the seventh
        do_reset();
        sel = 0;
        for (int k = 0; k < 6; k++) pix(k / 4, k % 4, 1'b0, 4, 4);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) pix(r, c, (r == 0 && c == 0), 4, 4);
        drain_check(0, 5, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
